// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand datapath.
// Contents:
//   DATA_W, NUM_ELEM  element width and elements per frame
//   PAIRS, OPS_W      lane count of the subtract stage and flat operand bus width
//   RES_W             subtract stage result width
//   bank_state_t      occupancy of one operand buffer bank
package matrix_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_ELEM = 32;
    localparam int PAIRS    = NUM_ELEM / 2;
    localparam int OPS_W    = DATA_W * NUM_ELEM;
    localparam int RES_W    = DATA_W * PAIRS;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

endpackage

// File: rtl/operand_bank.sv
// One frame buffer: NUM_ELEM x DATA_W register file with a single indexed
// write port and the whole contents exposed as one flat read bus.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears contents)
//   wr_en       write wr_data into slot wr_idx on this clock edge
//   wr_idx      slot index, 0 = first element of the frame
//   wr_data     element to store
//   rd_data     all slots, slot k at [W-1-DATA_W*k -: DATA_W] (slot 0 in MSBs)
module operand_bank #(
    parameter int DATA_W   = 16,
    parameter int NUM_ELEM = 32,
    parameter int IDX_W    = $clog2(NUM_ELEM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W*NUM_ELEM-1:0] rd_data
);

    localparam int FLAT_W = DATA_W * NUM_ELEM;

    logic [DATA_W-1:0] mem [NUM_ELEM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // First element lands in the most significant slice of the flat bus.
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_flat
        assign rd_data[FLAT_W-1-DATA_W*k -: DATA_W] = mem[k];
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Frame assembler in front of the 16-lane matrix subtract stage.
// Serial operands arrive over valid/ready and are collected into frames of
// NUM_ELEM elements in a ping-pong pair of banks: one bank fills while the
// other is presented on out_ops, so the input can take one element per cycle
// when the consumer keeps up.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   input handshake, in_data element, in_last frame marker
//   out_valid/out_ready output handshake, out_ops the whole frame (a1 in MSBs)
//   frame_err           one-cycle pulse when in_last disagrees with the count
module matrix_operand_loader #(
    parameter int DATA_W   = matrix_pkg::DATA_W,
    parameter int NUM_ELEM = matrix_pkg::NUM_ELEM
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W*NUM_ELEM-1:0] out_ops,
    output logic                       frame_err
);

    import matrix_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_ELEM);
    localparam int               FLAT_W   = DATA_W * NUM_ELEM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    logic [IDX_W-1:0]  cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic              init_done;
    bank_state_t       bank_state [2];
    logic [FLAT_W-1:0] bank_data  [2];

    logic accept;
    logic at_end;
    logic commit;
    logic early_end;
    logic release_frame;

    // Input readiness looks only at registered state, never at out_ready, so a
    // bank freed this cycle starts accepting on the next one.
    assign in_ready      = init_done && (bank_state[wr_bank] == EMPTY);
    assign out_valid     = (bank_state[rd_bank] == FULL);
    assign out_ops       = bank_data[rd_bank];

    assign accept        = in_valid && in_ready;
    assign at_end        = (cnt == LAST_IDX);
    assign commit        = accept && at_end;
    assign early_end     = accept && in_last && !at_end;
    assign release_frame = out_valid && out_ready;

    // An early in_last drops that element along with the partial frame, so it
    // is never written into the bank.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        operand_bank #(
            .DATA_W   (DATA_W),
            .NUM_ELEM (NUM_ELEM),
            .IDX_W    (IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (accept && !early_end && (wr_bank == 1'(g))),
            .wr_idx  (cnt),
            .wr_data (in_data),
            .rd_data (bank_data[g])
        );
    end

    // Fill counter, bank pointers and the framing error pulse. A frame that
    // reaches full length is always committed, with frame_err flagging a
    // missing in_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            init_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            init_done <= 1'b1;
            frame_err <= (commit && !in_last) || early_end;
            if (commit) begin
                cnt     <= '0;
                wr_bank <= ~wr_bank;
            end else if (early_end) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + IDX_W'(1);
            end
            if (release_frame) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Bank occupancy. Commit needs an EMPTY write bank and release needs a FULL
    // read bank, so both can happen in one cycle without touching the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (commit && (wr_bank == 1'(b))) begin
                    bank_state[b] <= FULL;
                end else if (release_frame && (rd_bank == 1'(b))) begin
                    bank_state[b] <= EMPTY;
                end
            end
        end
    end

endmodule
